bcd_display_scheduler: RTL

Shares one 12-bit binary-to-BCD encoder among up to four value producers (CPU register taps, PC, counters) and drives the DE0's four seven-segment digits. Producers post values over a req/ack handshake. A round-robin arbiter grants one per cycle, and the granted value is converted and stored in a per-source BCD slot. A dwell timer rotates which slot is shown; the operator can freeze or step the rotation.

---
 rtl/bcd_display_scheduler_pkg.sv | 42 ++++
 rtl/BCDEncoder.sv | 31 +++
 rtl/bcd_display_scheduler_seg7_decode.sv | 32 +++
 rtl/bcd_display_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// bcd_display_scheduler_pkg
// Shared constants and types for the BCD display scheduler:
//   BIN_W / BCD_W  : encoder input and output widths
//   MAX_SRC        : upper bound on the number of value producers
//   SEG_*          : active-low {g,f,e,d,c,b,a} patterns for digits 0-9
//   slot_arr_t     : per-source BCD result storage
//   onehot_to_idx  : converts a one-hot grant vector to its index
// ---------------------------------------------------------------------------
package bcd_display_scheduler_pkg;

  localparam int BIN_W   = 12;
  localparam int BCD_W   = 16;
  localparam int MAX_SRC = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  typedef logic [BCD_W-1:0] slot_arr_t [MAX_SRC];

  function automatic logic [1:0] onehot_to_idx(input logic [MAX_SRC-1:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/BCDEncoder.sv
// ---------------------------------------------------------------------------
// BCDEncoder
// Combinational 12-bit binary to 4-digit BCD converter (shift-and-add-3).
// Ports:
//   i_bin  in  12  binary value 0..4095
//   o_bcd  out 16  packed BCD digits {thousands, hundreds, tens, ones}
// ---------------------------------------------------------------------------
module BCDEncoder
  import bcd_display_scheduler_pkg::*;
(
  input  logic [BIN_W-1:0] i_bin,
  output logic [BCD_W-1:0] o_bcd
);

  logic [BCD_W+BIN_W-1:0] w_acc;

  // Double-dabble: before each shift, any BCD nibble above 4 gets +3.
  always_comb begin
    w_acc = {16'd0, i_bin};
    for (int i = 0; i < BIN_W; i++) begin
      for (int j = 0; j < 4; j++) begin
        w_acc[BIN_W+4*j +: 4] = (w_acc[BIN_W+4*j +: 4] > 4'd4) ?
                                (w_acc[BIN_W+4*j +: 4] + 4'd3) :
                                w_acc[BIN_W+4*j +: 4];
      end
      w_acc = {w_acc[BCD_W+BIN_W-2:0], 1'b0};
    end
    o_bcd = w_acc[BCD_W+BIN_W-1:BIN_W];
  end

endmodule

// File: rtl/bcd_display_scheduler_seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// One BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Ports:
//   i_digit  in  4  BCD digit; codes A-F are not expected and show blank
//   o_seg    out 7  active-low segment pattern
// ---------------------------------------------------------------------------
module seg7_decode
  import bcd_display_scheduler_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Digit lookup.
  always_comb begin
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_scheduler.sv
// ---------------------------------------------------------------------------
// bcd_display_scheduler
// Round-robin shares one BCDEncoder among NUM_SRC producers, stores each
// result in a per-source BCD slot and rotates one slot onto four 7-seg digits.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req[NUM_SRC]       level requests, held until ack
//   value_in           source i value at bits [12i+11:12i]
//   ack[NUM_SRC]       registered one-hot grant pulse
//   hold / next        freeze rotation / advance to next source
//   sel_src            index of the displayed source
//   hex0..hex3         registered active-low digits, hex0 = ones
// ---------------------------------------------------------------------------
module bcd_display_scheduler
  import bcd_display_scheduler_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DWELL   = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       req,
  input  logic [BIN_W*NUM_SRC-1:0] value_in,
  output logic [NUM_SRC-1:0]       ack,
  input  logic                     hold,
  input  logic                     next,
  output logic [1:0]               sel_src,
  output logic [6:0]               hex0,
  output logic [6:0]               hex1,
  output logic [6:0]               hex2,
  output logic [6:0]               hex3
);

  localparam int CNT_W = $clog2(DWELL);

  // Arbiter state and stage-1 conversion register
  logic [MAX_SRC-1:0] r_ack;
  logic [1:0]         r_ptr;
  logic [BIN_W-1:0]   r_conv_val;
  logic [1:0]         r_conv_idx;
  logic               r_conv_v;
  slot_arr_t          r_slot;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_sel;
  logic [6:0]         r_hex0, r_hex1, r_hex2, r_hex3;

  logic [MAX_SRC-1:0] w_req4, w_req_eff, w_grant;
  logic [1:0]         w_gidx, w_ptr_nxt, w_j, w_sel_inc;
  logic [2:0]         w_sum;
  logic               w_hit, w_any, w_term;
  logic [BIN_W-1:0]   w_val_sel;
  logic [BCD_W-1:0]   w_bcd, w_disp;
  logic [6:0]         w_seg0, w_seg1, w_seg2, w_seg3;
  logic               w_blank1, w_blank2, w_blank3;

  // Round-robin grant search starting at the pointer. A source whose ack is
  // currently high is masked so a level request held through its ack cycle
  // is not granted twice in a row.
  always_comb begin
    w_req4 = 4'd0;
    w_req4[NUM_SRC-1:0] = req;
    w_req_eff = w_req4 & ~r_ack;
    w_grant   = 4'd0;
    w_gidx    = 2'd0;
    w_any     = 1'b0;
    w_sum     = 3'd0;
    w_j       = 2'd0;
    w_hit     = 1'b0;
    // Walk from the farthest offset to the nearest so the nearest hit wins.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_sum   = {1'b0, r_ptr} + 3'(k);
      w_j     = (w_sum >= 3'(NUM_SRC)) ? 2'(w_sum - 3'(NUM_SRC)) : w_sum[1:0];
      w_hit   = w_req_eff[w_j];
      w_grant = w_hit ? (4'd1 << w_j) : w_grant;
      w_gidx  = w_hit ? w_j : w_gidx;
      w_any   = w_any | w_hit;
    end
    w_ptr_nxt = (w_gidx == 2'(NUM_SRC - 1)) ? 2'd0 : (w_gidx + 2'd1);
  end

  // Value of the source being acked this cycle.
  always_comb begin
    w_val_sel = 12'd0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_val_sel = r_ack[k] ? value_in[k*BIN_W +: BIN_W] : w_val_sel;
    end
  end

  // Arbiter pointer, registered ack and stage-1 capture on the ack cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack      <= 4'd0;
      r_ptr      <= 2'd0;
      r_conv_val <= 12'd0;
      r_conv_idx <= 2'd0;
      r_conv_v   <= 1'b0;
    end else begin
      r_ack    <= w_grant;
      r_conv_v <= |r_ack;
      if (w_any) begin
        r_ptr <= w_ptr_nxt;
      end
      if (|r_ack) begin
        r_conv_val <= w_val_sel;
        r_conv_idx <= onehot_to_idx(r_ack);
      end
    end
  end

  BCDEncoder u_enc (
    .i_bin (r_conv_val),
    .o_bcd (w_bcd)
  );

  // Per-source BCD result slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_SRC; k++) begin
        r_slot[k] <= 16'd0;
      end
    end else if (r_conv_v) begin
      r_slot[r_conv_idx] <= w_bcd;
    end
  end

  assign w_term    = (r_cnt == CNT_W'(DWELL - 1));
  assign w_sel_inc = (r_sel == 2'(NUM_SRC - 1)) ? 2'd0 : (r_sel + 2'd1);

  // Dwell timer and displayed-source select; next overrides hold and a
  // coincident terminal count still advances by only one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sel <= 2'd0;
    end else if (next) begin
      r_cnt <= '0;
      r_sel <= w_sel_inc;
    end else if (!hold) begin
      if (w_term) begin
        r_cnt <= '0;
        r_sel <= w_sel_inc;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_disp = r_slot[r_sel];

  seg7_decode u_seg0 (.i_digit(w_disp[3:0]),   .o_seg(w_seg0));
  seg7_decode u_seg1 (.i_digit(w_disp[7:4]),   .o_seg(w_seg1));
  seg7_decode u_seg2 (.i_digit(w_disp[11:8]),  .o_seg(w_seg2));
  seg7_decode u_seg3 (.i_digit(w_disp[15:12]), .o_seg(w_seg3));

  // Leading-zero blanking; the ones digit is never blanked.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    w_blank3 = (w_disp[15:12] == 4'd0);
    w_blank2 = w_blank3 && (w_disp[11:8] == 4'd0);
    w_blank1 = w_blank2 && (w_disp[7:4] == 4'd0);
`else
    w_blank3 = 1'b0;
    w_blank2 = 1'b0;
    w_blank1 = 1'b0;
`endif
  end

  // Registered digit outputs, all four update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex0 <= SEG_BLANK;
      r_hex1 <= SEG_BLANK;
      r_hex2 <= SEG_BLANK;
      r_hex3 <= SEG_BLANK;
    end else begin
      r_hex0 <= w_seg0;
      r_hex1 <= w_blank1 ? SEG_BLANK : w_seg1;
      r_hex2 <= w_blank2 ? SEG_BLANK : w_seg2;
      r_hex3 <= w_blank3 ? SEG_BLANK : w_seg3;
    end
  end

  assign ack     = r_ack[NUM_SRC-1:0];
  assign sel_src = r_sel;
  assign hex0    = r_hex0;
  assign hex1    = r_hex1;
  assign hex2    = r_hex2;
  assign hex3    = r_hex3;

endmodule
